// File: rtl/z_event_logger_if.sv
// Record handshake between the event logger and its consumer.
// The logger drives the head record, and the consumer drives ev_ready.
interface z_event_logger_if #(
    parameter int unsigned TSW = 8
) ();
    logic           ev_valid;
    logic           ev_ready;
    logic [1:0]     ev_code;
    logic [TSW-1:0] ev_time;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_time,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_time,
        output ev_ready
    );
endinterface

// File: rtl/z_event_logger.sv
// Classifies recognizer Z codes and timestamps them into a show-ahead FIFO drained by valid/ready.
// Optional Z_EVENT_LOGGER_CLR_EN adds a clr input that zeroes the counters and sticky flags.
module z_event_logger #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TSW   = 8,
    parameter int unsigned CW    = 8
) (
    input  logic              Ck,
    input  logic              reset_,
    input  logic [1:0]        Z,
    z_event_logger_if.master  ev,
`ifdef Z_EVENT_LOGGER_CLR_EN
    input  logic              clr,
`endif
    output logic [CW-1:0]     cnt_a,
    output logic [CW-1:0]     cnt_b,
    output logic              overflow,
    output logic              err
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] FullOcc = DEPTH[AW:0];

    logic [TSW-1:0] ts_q, ts_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    occ_q, occ_d;
    logic [1:0]     code_mem_q [DEPTH];
    logic [1:0]     code_mem_d [DEPTH];
    logic [TSW-1:0] time_mem_q [DEPTH];
    logic [TSW-1:0] time_mem_d [DEPTH];
    logic [CW-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic           overflow_q, overflow_d, err_q, err_d;

    logic is_a, is_b, is_ev, not_empty, full, pop, push, drop, clr_w;

`ifdef Z_EVENT_LOGGER_CLR_EN
    assign clr_w = clr;
`else
    assign clr_w = 1'b0;
`endif

    assign is_a      = (Z == 2'b11);
    assign is_b      = (Z == 2'b10);
    assign is_ev     = is_a | is_b;
    assign not_empty = (occ_q != '0);
    assign full      = (occ_q == FullOcc);
    assign pop       = not_empty & ev.ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push      = is_ev & (~full | pop);
    assign drop      = is_ev & full & ~pop;

    always_comb begin
        ts_d       = ts_q + TSW'(1);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        code_mem_d = code_mem_q;
        time_mem_d = time_mem_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        overflow_d = overflow_q | drop;
        err_d      = err_q | (Z == 2'b01);

        if (push) begin
            code_mem_d[wr_ptr_q] = Z;
            time_mem_d[wr_ptr_q] = ts_q;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + (AW+1)'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - (AW+1)'(1);
        end

        if (is_a && (cnt_a_q != '1)) begin
            cnt_a_d = cnt_a_q + CW'(1);
        end
        if (is_b && (cnt_b_q != '1)) begin
            cnt_b_d = cnt_b_q + CW'(1);
        end

        // Clear beats a coincident event; the record itself is still queued.
        if (clr_w) begin
            cnt_a_d    = '0;
            cnt_b_d    = '0;
            overflow_d = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge Ck) begin
        if (reset_) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
        code_mem_q <= code_mem_d;
        time_mem_q <= time_mem_d;
    end

    assign ev.ev_valid = not_empty;
    assign ev.ev_code  = not_empty ? code_mem_q[rd_ptr_q] : 2'b00;
    assign ev.ev_time  = not_empty ? time_mem_q[rd_ptr_q] : '0;
    assign cnt_a       = cnt_a_q;
    assign cnt_b       = cnt_b_q;
    assign overflow    = overflow_q;
    assign err         = err_q;
endmodule

// File: tb/tb_z_event_logger.sv
// Directed bench for z_event_logger, with a second CW=3 instance on the same stimulus
// that exercises counter saturation.
module tb_z_event_logger;
    logic       Ck = 1'b0;
    logic       reset_;
    logic [1:0] Z;
    logic       ready_s;
    logic [7:0] cnt_a, cnt_b;
    logic       overflow, err;
    logic [2:0] cnt_a3, cnt_b3;
    logic       overflow3, err3;
`ifdef Z_EVENT_LOGGER_CLR_EN
    logic       clr_s = 1'b0;
`endif

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 Ck = ~Ck;

    z_event_logger_if #(.TSW(8)) ev_if  ();
    z_event_logger_if #(.TSW(8)) ev_if3 ();
    assign ev_if.ev_ready  = ready_s;
    assign ev_if3.ev_ready = ready_s;

    z_event_logger #(.DEPTH(4), .TSW(8), .CW(8)) u_dut (
        .Ck       (Ck),
        .reset_   (reset_),
        .Z        (Z),
        .ev       (ev_if),
`ifdef Z_EVENT_LOGGER_CLR_EN
        .clr      (clr_s),
`endif
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
        .overflow (overflow),
        .err      (err)
    );

    z_event_logger #(.DEPTH(4), .TSW(8), .CW(3)) u_dut_c3 (
        .Ck       (Ck),
        .reset_   (reset_),
        .Z        (Z),
        .ev       (ev_if3),
`ifdef Z_EVENT_LOGGER_CLR_EN
        .clr      (clr_s),
`endif
        .cnt_a    (cnt_a3),
        .cnt_b    (cnt_b3),
        .overflow (overflow3),
        .err      (err3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Ck);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [1:0] code, input logic [7:0] t);
        check_eq({tag, "_valid"}, 32'(ev_if.ev_valid), 32'd1);
        check_eq({tag, "_code"}, 32'(ev_if.ev_code), 32'(code));
        check_eq({tag, "_time"}, 32'(ev_if.ev_time), 32'(t));
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_valid"}, 32'(ev_if.ev_valid), 32'd0);
        check_eq({tag, "_code"}, 32'(ev_if.ev_code), 32'd0);
        check_eq({tag, "_time"}, 32'(ev_if.ev_time), 32'd0);
        check_eq({tag, "_cnt_a"}, 32'(cnt_a), 32'd0);
        check_eq({tag, "_cnt_b"}, 32'(cnt_b), 32'd0);
        check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
    endtask

    logic [1:0] fill_codes [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    logic [1:0] drain_code [3] = '{2'b10, 2'b11, 2'b11};
    logic [7:0] drain_time [3] = '{8'd2, 8'd3, 8'd4};

    initial begin
        reset_  = 1'b1;
        Z       = 2'b00;
        ready_s = 1'b1;
        tick();
        tick();
        check_idle("rst");

        // Ten idle edges, then an event proves the timestamp reached 10.
        reset_ = 1'b0;
        repeat (10) tick();
        check_idle("idle");
        Z = 2'b11; ready_s = 1'b0;
        tick();
        check_head("ts10", 2'b11, 8'd10);

        // Single event on the 5th edge after release.
        Z = 2'b00; reset_ = 1'b1;
        tick();
        reset_ = 1'b0;
        repeat (4) tick();
        Z = 2'b11;
        tick();
        check_head("single", 2'b11, 8'd4);
        check_eq("single_cnt_a", 32'(cnt_a), 32'd1);
        Z = 2'b00; ready_s = 1'b1;
        tick();
        check_eq("single_pop_valid", 32'(ev_if.ev_valid), 32'd0);

        // Fill to DEPTH with no pop.
        reset_ = 1'b1; ready_s = 1'b0;
        tick();
        reset_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Z = fill_codes[i];
            tick();
        end
        check_head("fill", 2'b10, 8'd0);
        check_eq("fill_ovf", 32'(overflow), 32'd0);
        check_eq("fill_cnt_a", 32'(cnt_a), 32'd2);
        check_eq("fill_cnt_b", 32'(cnt_b), 32'd2);

        // Full with push and pop on the same edge.
        Z = 2'b11; ready_s = 1'b1;
        tick();
        check_head("pushpop", 2'b11, 8'd1);
        check_eq("pushpop_ovf", 32'(overflow), 32'd0);
        check_eq("pushpop_cnt_a", 32'(cnt_a), 32'd3);

        // Full and no pop: record dropped, counter still counts.
        Z = 2'b10; ready_s = 1'b0;
        tick();
        check_head("drop", 2'b11, 8'd1);
        check_eq("drop_ovf", 32'(overflow), 32'd1);
        check_eq("drop_cnt_b", 32'(cnt_b), 32'd3);

        Z = 2'b00; ready_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_head($sformatf("drain%0d", i), drain_code[i], drain_time[i]);
        end
        tick();
        check_eq("drain_empty", 32'(ev_if.ev_valid), 32'd0);

        // Illegal code.
        Z = 2'b01; ready_s = 1'b0;
        tick();
        check_eq("illegal_err", 32'(err), 32'd1);
        check_eq("illegal_valid", 32'(ev_if.ev_valid), 32'd0);
        check_eq("illegal_cnt_a", 32'(cnt_a), 32'd3);
        check_eq("illegal_cnt_b", 32'(cnt_b), 32'd3);
        check_eq("sticky_ovf", 32'(overflow), 32'd1);

        // Saturation: 9 A events, streaming through the FIFO.
        Z = 2'b00; reset_ = 1'b1;
        tick();
        reset_ = 1'b0;
        check_eq("sat_err_cleared", 32'(err), 32'd0);
        Z = 2'b11; ready_s = 1'b1;
        repeat (9) tick();
        check_eq("sat_cnt_a8", 32'(cnt_a), 32'd9);
        check_eq("sat_cnt_a3", 32'(cnt_a3), 32'd7);
        check_head("sat_head", 2'b11, 8'd8);

        // Timestamp wrap: advance from 9 to 255.
        Z = 2'b00;
        repeat (246) tick();
        Z = 2'b11; ready_s = 1'b0;
        tick();
        tick();
        check_head("wrap255", 2'b11, 8'd255);
        Z = 2'b00; ready_s = 1'b1;
        tick();
        check_head("wrap0", 2'b11, 8'd0);

        // Reset with two records queued.
        Z = 2'b10; ready_s = 1'b0;
        tick();
        reset_ = 1'b1; Z = 2'b00;
        tick();
        check_idle("midrst");
        reset_ = 1'b0; Z = 2'b11;
        tick();
        check_head("post_rst", 2'b11, 8'd0);
        check_eq("post_rst_cnt_a", 32'(cnt_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
